comm_fpga_fx2_v2: RTL and testbench

COMM_FPGA_FX2_V2 -- requirements
Module: comm_fpga_fx2_v2

---
 rtl/comm_fpga_fx2_v2_pkg.sv | 25 ++
 rtl/comm_fpga_fx2_v2.sv | 168 ++++++++++++++++
 tb/tb_comm_fpga_fx2_v2.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comm_fpga_fx2_v2_pkg.sv
// Shared types and constants for the FX2 FIFO-to-channel bridge.
package comm_fpga_fx2_v2_pkg;

  // FX2 high-speed bulk endpoint size in bytes
  localparam int unsigned EP_SIZE = 512;
  localparam int unsigned EP_BITS = $clog2(EP_SIZE);

  // Value of fx2FifoSel_out selecting each FX2 FIFO
  localparam logic FIFO_OUT = 1'b0;  // host -> FPGA
  localparam logic FIFO_IN  = 1'b1;  // FPGA -> host

  typedef enum logic [3:0] {
    StIdle,
    StGetCount0,
    StGetCount1,
    StGetCount2,
    StGetCount3,
    StBeginWrite,
    StWrite,
    StEndWriteAligned,
    StEndWriteNonaligned,
    StRead
  } state_e;

endpackage

// File: rtl/comm_fpga_fx2_v2.sv
// FX2 FIFO bridge: decodes command/count header from the OUT FIFO, then
// streams bytes host->FPGA (h2f) or FPGA->host (f2h) on the selected channel.
module comm_fpga_fx2_v2
  import comm_fpga_fx2_v2_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset_in,
  output logic       fx2FifoSel_out,
  input  logic [7:0] fx2Data_in,
  output logic [7:0] fx2Data_out,
  output logic       fx2Data_sel,
  output logic       fx2Read_out,
  input  logic       fx2GotData_in,
  output logic       fx2Write_out,
  input  logic       fx2GotRoom_in,
  output logic       fx2PktEnd_out,
  output logic [6:0] chanAddr_out,
  output logic [7:0] h2fData_out,
  output logic       h2fValid_out,
  input  logic       h2fReady_in,
  input  logic [7:0] f2hData_in,
  input  logic       f2hValid_in,
  output logic       f2hReady_out
);

  state_e      r_state, w_state_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic [6:0]  r_chan,  w_chan_nxt;
  logic        r_dir,   w_dir_nxt;
  logic        r_aligned, w_aligned_nxt;
  logic [31:0] w_count_full;

  // Full count as it stands once the final count byte is on the bus
  assign w_count_full = {r_count[31:8], fx2Data_in};
  assign chanAddr_out = r_chan;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_chan    <= '0;
      r_dir     <= 1'b0;
      r_aligned <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_chan    <= w_chan_nxt;
      r_dir     <= w_dir_nxt;
      r_aligned <= w_aligned_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_chan_nxt    = r_chan;
    w_dir_nxt     = r_dir;
    w_aligned_nxt = r_aligned;
    unique case (r_state)
      StIdle: begin
        if (fx2GotData_in) begin
          w_dir_nxt   = fx2Data_in[7];
          w_chan_nxt  = fx2Data_in[6:0];
          w_state_nxt = StGetCount0;
        end
      end
      StGetCount0: begin
        if (fx2GotData_in) begin
          w_count_nxt[31:24] = fx2Data_in;
          w_state_nxt        = StGetCount1;
        end
      end
      StGetCount1: begin
        if (fx2GotData_in) begin
          w_count_nxt[23:16] = fx2Data_in;
          w_state_nxt        = StGetCount2;
        end
      end
      StGetCount2: begin
        if (fx2GotData_in) begin
          w_count_nxt[15:8] = fx2Data_in;
          w_state_nxt       = StGetCount3;
        end
      end
      StGetCount3: begin
        if (fx2GotData_in) begin
          w_count_nxt = w_count_full;
          if (w_count_full == 32'd0) begin
            w_state_nxt = StIdle;
          end else if (r_dir) begin
            w_state_nxt = StBeginWrite;
          end else begin
            w_state_nxt = StRead;
          end
        end
      end
      StBeginWrite: begin
        // A whole number of endpoints commits itself; otherwise a short packet needs PKTEND
        w_aligned_nxt = (r_count[EP_BITS-1:0] == '0);
        w_state_nxt   = StWrite;
      end
      StWrite: begin
        if (fx2GotRoom_in && f2hValid_in) begin
          w_count_nxt = r_count - 32'd1;
          if (r_count == 32'd1) begin
            w_state_nxt = r_aligned ? StEndWriteAligned : StEndWriteNonaligned;
          end
        end
      end
      StEndWriteAligned: begin
        w_state_nxt = StIdle;
      end
      StEndWriteNonaligned: begin
        if (fx2GotRoom_in) begin
          w_state_nxt = StIdle;
        end
      end
      StRead: begin
        if (fx2GotData_in && h2fReady_in) begin
          w_count_nxt = r_count - 32'd1;
          if (r_count == 32'd1) begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output decode from current state and live FIFO/stream handshakes
  always_comb begin
    fx2FifoSel_out = FIFO_OUT;
    fx2Read_out    = 1'b1;
    fx2Write_out   = 1'b1;
    fx2PktEnd_out  = 1'b1;
    fx2Data_sel    = 1'b0;
    fx2Data_out    = f2hData_in;
    h2fData_out    = fx2Data_in;
    h2fValid_out   = 1'b0;
    f2hReady_out   = 1'b0;
    unique case (r_state)
      StIdle, StGetCount0, StGetCount1, StGetCount2, StGetCount3: begin
        fx2Read_out = !fx2GotData_in;
      end
      StBeginWrite, StEndWriteAligned: begin
        fx2FifoSel_out = FIFO_IN;
      end
      StWrite: begin
        fx2FifoSel_out = FIFO_IN;
        fx2Data_sel    = 1'b1;
        f2hReady_out   = fx2GotRoom_in;
        fx2Write_out   = !(fx2GotRoom_in && f2hValid_in);
      end
      StEndWriteNonaligned: begin
        fx2FifoSel_out = FIFO_IN;
        fx2PktEnd_out  = !fx2GotRoom_in;
      end
      StRead: begin
        h2fValid_out = fx2GotData_in;
        fx2Read_out  = !(fx2GotData_in && h2fReady_in);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_comm_fpga_fx2_v2.sv
// Self-checking bench for comm_fpga_fx2_v2: directed vector table, multi-cycle
// corner sequences and randomized transactions against a queue-based host model.
module tb_comm_fpga_fx2_v2;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       fx2FifoSel_out;
  logic [7:0] fx2Data_in;
  logic [7:0] fx2Data_out;
  logic       fx2Data_sel;
  logic       fx2Read_out;
  logic       fx2GotData_in;
  logic       fx2Write_out;
  logic       fx2GotRoom_in;
  logic       fx2PktEnd_out;
  logic [6:0] chanAddr_out;
  logic [7:0] h2fData_out;
  logic       h2fValid_out;
  logic       h2fReady_in;
  logic [7:0] f2hData_in;
  logic       f2hValid_in;
  logic       f2hReady_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  comm_fpga_fx2_v2 dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .fx2FifoSel_out(fx2FifoSel_out),
    .fx2Data_in    (fx2Data_in),
    .fx2Data_out   (fx2Data_out),
    .fx2Data_sel   (fx2Data_sel),
    .fx2Read_out   (fx2Read_out),
    .fx2GotData_in (fx2GotData_in),
    .fx2Write_out  (fx2Write_out),
    .fx2GotRoom_in (fx2GotRoom_in),
    .fx2PktEnd_out (fx2PktEnd_out),
    .chanAddr_out  (chanAddr_out),
    .h2fData_out   (h2fData_out),
    .h2fValid_out  (h2fValid_out),
    .h2fReady_in   (h2fReady_in),
    .f2hData_in    (f2hData_in),
    .f2hValid_in   (f2hValid_in),
    .f2hReady_out  (f2hReady_out)
  );

  typedef struct {
    logic       gd;
    logic [7:0] din;
    logic       hr;
    logic       room;
    logic       fv;
    logic [7:0] fd;
    logic       e_sel;
    logic       e_rd;
    logic       e_wr;
    logic       e_pe;
    logic       e_dsel;
    logic       e_hv;
    logic [7:0] e_hd;
    logic       e_fr;
    logic [6:0] e_ch;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later
  task automatic drive(input logic gd, input logic [7:0] din, input logic hr,
                       input logic room, input logic fv, input logic [7:0] fd);
    @(negedge clk_in);
    fx2GotData_in = gd;
    fx2Data_in    = din;
    h2fReady_in   = hr;
    fx2GotRoom_in = room;
    f2hValid_in   = fv;
    f2hData_in    = fd;
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] cnt);
    drive(1'b1, cmd, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 3; i >= 0; i--) begin
      drive(1'b1, cnt[i*8 +: 8], 1'b0, 1'b0, 1'b0, 8'h00);
    end
  endtask

  // One randomized transaction; expected behaviour comes from byte queues
  task automatic run_txn(input logic dir, input logic [6:0] chan, input int cnt);
    logic [7:0] host_q[$];
    logic [7:0] h2f_exp[$];
    logic [7:0] f2h_q[$];
    logic [31:0] c32;
    int consumed, pkt, pkt_exp;
    logic gd, hr, room, fv, done;
    logic [7:0] din, fd, b;
    c32 = cnt;
    host_q.push_back({dir, chan});
    for (int i = 3; i >= 0; i--) host_q.push_back(c32[i*8 +: 8]);
    for (int i = 0; i < cnt; i++) begin
      b = 8'($urandom);
      if (dir) f2h_q.push_back(b);
      else begin
        host_q.push_back(b);
        h2f_exp.push_back(b);
      end
    end
    pkt_exp  = (dir && cnt != 0 && (cnt % 512) != 0) ? 1 : 0;
    consumed = 0;
    pkt      = 0;
    done     = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      done = host_q.size() == 0 && h2f_exp.size() == 0 && f2h_q.size() == 0 && pkt >= pkt_exp;
      if (done) break;
      gd   = host_q.size() > 0 && $urandom_range(0, 3) != 0;
      din  = gd ? host_q[0] : 8'($urandom);
      hr   = $urandom_range(0, 2) != 0;
      room = $urandom_range(0, 3) != 0;
      fv   = f2h_q.size() > 0 && $urandom_range(0, 3) != 0;
      fd   = fv ? f2h_q[0] : 8'($urandom);
      drive(gd, din, hr, room, fv, fd);
      if (h2fValid_out && hr) begin
        chk("h2f_with_read_strobe", {31'd0, !fx2Read_out}, 32'd1);
        chk("h2f_pending", {31'd0, h2f_exp.size() > 0}, 32'd1);
        if (h2f_exp.size() > 0) begin
          chk("h2f_data", {24'd0, h2fData_out}, {24'd0, h2f_exp[0]});
          void'(h2f_exp.pop_front());
        end
      end
      if (!fx2Read_out) begin
        chk("read_needs_data", {31'd0, gd}, 32'd1);
        if (consumed >= 5) chk("read_is_h2f_xfer", {31'd0, h2fValid_out && hr}, 32'd1);
        if (host_q.size() > 0) void'(host_q.pop_front());
        consumed++;
      end
      if (!fx2Write_out) begin
        chk("write_handshake", {29'd0, fx2FifoSel_out, fx2Data_sel, f2hReady_out},
            {29'd0, 1'b1, 1'b1, 1'b1});
        chk("write_pending", {31'd0, f2h_q.size() > 0}, 32'd1);
        if (f2h_q.size() > 0) begin
          chk("write_data", {24'd0, fx2Data_out}, {24'd0, f2h_q[0]});
          void'(f2h_q.pop_front());
        end
      end
      if (!fx2PktEnd_out) begin
        chk("pktend_room", {31'd0, room}, 32'd1);
        pkt++;
        chk("pktend_count", pkt, pkt_exp);
      end
    end
    chk("txn_done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00);
      chk("idle_no_strobe", {29'd0, fx2Read_out, fx2Write_out, fx2PktEnd_out}, 32'd7);
    end
    chk("idle_fifosel", {31'd0, fx2FifoSel_out}, 32'd0);
    chk("txn_chan", {25'd0, chanAddr_out}, {25'd0, chan});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes, pkts;
    vec_t v;
    reset_in      = 1'b1;
    fx2GotData_in = 1'b0;
    fx2Data_in    = 8'h00;
    h2fReady_in   = 1'b0;
    fx2GotRoom_in = 1'b0;
    f2hValid_in   = 1'b0;
    f2hData_in    = 8'h00;
    @(negedge clk_in);
    @(negedge clk_in);
    #1;
    chk("rst_outs", {25'd0, fx2FifoSel_out, fx2Read_out, fx2Write_out, fx2PktEnd_out,
                     fx2Data_sel, h2fValid_out, f2hReady_out}, {25'd0, 7'b0111000});
    chk("rst_chan", {25'd0, chanAddr_out}, 32'd0);
    reset_in = 1'b0;

    // gd din hr room fv fd | sel rd wr pe dsel hv hd fr ch
    // Host write, channel 5, three bytes, one backpressure stall
    tbl.push_back('{1, 8'h05, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd0});
    tbl.push_back('{1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd5});
    tbl.push_back('{1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd5});
    tbl.push_back('{1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd5});
    tbl.push_back('{1, 8'h03, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd5});
    tbl.push_back('{1, 8'hAA, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 8'hAA, 0, 7'd5});
    tbl.push_back('{1, 8'hBB, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 1, 8'hBB, 0, 7'd5});
    tbl.push_back('{0, 8'hBB, 1, 0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 8'h00, 0, 7'd5});
    tbl.push_back('{1, 8'hBB, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 8'hBB, 0, 7'd5});
    tbl.push_back('{1, 8'hCC, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 8'hCC, 0, 7'd5});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 8'h00, 0, 7'd5});
    // Host read, channel 2, four bytes, stalls then short-packet commit
    tbl.push_back('{1, 8'h82, 0, 1, 1, 8'h11, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd5});
    tbl.push_back('{1, 8'h00, 0, 1, 1, 8'h11, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd2});
    tbl.push_back('{1, 8'h00, 0, 1, 1, 8'h11, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd2});
    tbl.push_back('{1, 8'h00, 0, 1, 1, 8'h11, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd2});
    tbl.push_back('{1, 8'h04, 0, 1, 1, 8'h11, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd2});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 8'h11, 1, 1, 1, 1, 0, 0, 8'h00, 0, 7'd2});
    tbl.push_back('{0, 8'h00, 0, 1, 0, 8'h11, 1, 1, 1, 1, 1, 0, 8'h00, 1, 7'd2});
    tbl.push_back('{0, 8'h00, 0, 0, 1, 8'h11, 1, 1, 1, 1, 1, 0, 8'h00, 0, 7'd2});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 8'h11, 1, 1, 0, 1, 1, 0, 8'h00, 1, 7'd2});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 8'h12, 1, 1, 0, 1, 1, 0, 8'h00, 1, 7'd2});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 8'h13, 1, 1, 0, 1, 1, 0, 8'h00, 1, 7'd2});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 8'h14, 1, 1, 0, 1, 1, 0, 8'h00, 1, 7'd2});
    tbl.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 0, 8'h00, 0, 7'd2});
    tbl.push_back('{0, 8'h00, 0, 1, 0, 8'h00, 1, 1, 1, 0, 0, 0, 8'h00, 0, 7'd2});
    tbl.push_back('{0, 8'h00, 0, 1, 0, 8'h00, 0, 1, 1, 1, 0, 0, 8'h00, 0, 7'd2});
    // Zero-count commands return straight to idle (next byte is a command, not data)
    tbl.push_back('{1, 8'h01, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd2});
    tbl.push_back('{1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd1});
    tbl.push_back('{1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd1});
    tbl.push_back('{1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd1});
    tbl.push_back('{1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd1});
    tbl.push_back('{1, 8'h00, 1, 1, 1, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd1});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1, 8'h00, 1, 1, 1, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 7'd0});
    tbl.push_back('{0, 8'h00, 1, 1, 1, 8'h00, 0, 1, 1, 1, 0, 0, 8'h00, 0, 7'd0});

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.gd, v.din, v.hr, v.room, v.fv, v.fd);
      chk($sformatf("v%0d_sel", i), {31'd0, fx2FifoSel_out}, {31'd0, v.e_sel});
      chk($sformatf("v%0d_rd", i), {31'd0, fx2Read_out}, {31'd0, v.e_rd});
      chk($sformatf("v%0d_wr", i), {31'd0, fx2Write_out}, {31'd0, v.e_wr});
      chk($sformatf("v%0d_pktend", i), {31'd0, fx2PktEnd_out}, {31'd0, v.e_pe});
      chk($sformatf("v%0d_dsel", i), {31'd0, fx2Data_sel}, {31'd0, v.e_dsel});
      chk($sformatf("v%0d_hvalid", i), {31'd0, h2fValid_out}, {31'd0, v.e_hv});
      chk($sformatf("v%0d_f2hready", i), {31'd0, f2hReady_out}, {31'd0, v.e_fr});
      chk($sformatf("v%0d_chan", i), {25'd0, chanAddr_out}, {25'd0, v.e_ch});
      if (v.e_hv) chk($sformatf("v%0d_hdata", i), {24'd0, h2fData_out}, {24'd0, v.e_hd});
      if (v.e_dsel) chk($sformatf("v%0d_fx2data", i), {24'd0, fx2Data_out}, {24'd0, v.fd});
    end

    // 512-byte read fills the endpoint exactly: no PKTEND
    send_hdr(8'h83, 32'h0000_0200);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
    chk("al_begin", {30'd0, fx2FifoSel_out, fx2Write_out}, 32'd3);
    strobes = 0;
    pkts    = 0;
    for (int i = 0; i < 512; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'(i));
      if (!fx2Write_out) strobes++;
      if (!fx2PktEnd_out) pkts++;
    end
    chk("al_strobes", strobes, 512);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
    chk("al_end", {29'd0, fx2FifoSel_out, fx2Write_out, fx2PktEnd_out}, 32'd7);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
    if (!fx2PktEnd_out) pkts++;
    chk("al_no_pktend", pkts, 0);
    chk("al_idle", {30'd0, fx2FifoSel_out, fx2Write_out}, 32'd1);

    // Reset in the middle of a 100-byte host write
    send_hdr(8'h07, 32'd100);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 8'h00);
    chk("mid_hvalid", {31'd0, h2fValid_out}, 32'd1);
    @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
    fx2GotData_in = 1'b1;
    fx2Data_in    = 8'h03;
    #1;
    chk("rst_mid_hvalid", {31'd0, h2fValid_out}, 32'd0);
    chk("rst_mid_chan", {25'd0, chanAddr_out}, 32'd0);
    chk("rst_mid_rd", {31'd0, fx2Read_out}, 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("post_rst_chan", {25'd0, chanAddr_out}, 32'd3);
    chk("post_rst_data", {23'd0, h2fValid_out, h2fData_out}, {23'd0, 1'b1, 8'h5A});
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("post_rst_done", {31'd0, h2fValid_out}, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);

    // Randomized transactions in both directions
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom_range(0, 20));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
